// File: rtl/isb_param.sv
`default_nettype none
// ============================================================================
// Module   : isb_param
// Brief    : Parametrised ISB temporal prefetcher (TU -> PS/SP address maps,
//            DEGREE-deep prefetch issue). Option macro: ISB_PF_DEDUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module isb_param #(
    parameter int PC_W       = 16,
    parameter int ADDR_W     = 16,
    parameter int TU_ENTRIES = 4,
    parameter int PS_ENTRIES = 32,
    parameter int SA_W       = 8,
    parameter int STREAM_LEN = 16,
    parameter int DEGREE     = 2,
    parameter int CONF_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_in,
    input  logic [PC_W-1:0]   pc,
    input  logic [ADDR_W-1:0] addr,
    input  logic              prefetch_ready,
    output logic              prefetch_v,
    output logic [ADDR_W-1:0] prefetch_addr,
    output logic              busy
);
    localparam int c_TU_IW    = (TU_ENTRIES > 1) ? $clog2(TU_ENTRIES) : 1;
    localparam int c_PS_IW    = (PS_ENTRIES > 1) ? $clog2(PS_ENTRIES) : 1;
    localparam int c_SP_DEPTH = 1 << SA_W;
    localparam int c_K_W      = (DEGREE > 1) ? $clog2(DEGREE + 1) : 1;
    localparam logic [SA_W-1:0] c_SL_MASK = SA_W'(STREAM_LEN - 1);
    localparam logic [SA_W-1:0] c_SL_STEP = SA_W'(STREAM_LEN);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_CHECK = 2'd2;
    localparam logic [1:0] c_S_SEND  = 2'd3;

    logic              r_tu_v    [TU_ENTRIES];
    logic [PC_W-1:0]   r_tu_pc   [TU_ENTRIES];
    logic [ADDR_W-1:0] r_tu_last [TU_ENTRIES];
    logic [c_TU_IW-1:0] r_tu_age [TU_ENTRIES];

    logic              r_ps_v    [PS_ENTRIES];
    logic [ADDR_W-1:0] r_ps_addr [PS_ENTRIES];
    logic [SA_W-1:0]   r_ps_sa   [PS_ENTRIES];
    logic [CONF_W-1:0] r_ps_conf [PS_ENTRIES];
    logic [c_PS_IW-1:0] r_rr;
    logic [SA_W-1:0]   r_next_sa;

    logic              r_sp_v  [c_SP_DEPTH];
    logic [ADDR_W-1:0] r_sp_pa [c_SP_DEPTH];

    logic [1:0]        r_state;
    logic [SA_W-1:0]   r_base;
    logic [c_K_W-1:0]  r_k;
    logic              r_rd_v;
    logic [ADDR_W-1:0] r_rd_pa;
    logic              r_pf_v;
    logic [ADDR_W-1:0] r_pf_addr;

    logic               w_tu_hit;
    logic [c_TU_IW-1:0] w_tu_idx, w_tu_vic, w_touch;
    logic [ADDR_W-1:0]  w_a;
    logic               w_a_hit, w_b_hit;
    logic [c_PS_IW-1:0] w_a_idx, w_b_idx;

    always_comb begin
        w_tu_hit = 1'b0;
        w_tu_idx = '0;
        w_tu_vic = '0;
        for (int i = 0; i < TU_ENTRIES; i++) begin
            if (r_tu_v[i] && r_tu_pc[i] == pc) begin
                w_tu_hit = 1'b1;
                w_tu_idx = c_TU_IW'(i);
            end
            if (r_tu_age[i] == c_TU_IW'(TU_ENTRIES - 1))
                w_tu_vic = c_TU_IW'(i);
        end
        w_touch = w_tu_hit ? w_tu_idx : w_tu_vic;
        w_a     = r_tu_last[w_tu_idx];
    end

    always_comb begin
        w_a_hit = 1'b0;
        w_a_idx = '0;
        w_b_hit = 1'b0;
        w_b_idx = '0;
        for (int i = 0; i < PS_ENTRIES; i++) begin
            if (r_ps_v[i] && r_ps_addr[i] == w_a) begin
                w_a_hit = 1'b1;
                w_a_idx = c_PS_IW'(i);
            end
            if (r_ps_v[i] && r_ps_addr[i] == addr) begin
                w_b_hit = 1'b1;
                w_b_idx = c_PS_IW'(i);
            end
        end
    end

    // Training decode: A is the PC's previous address, B the current one.
    logic               w_train, w_alloc_a, w_alloc_b, w_b_map, w_b_seq, w_full;
    logic [SA_W-1:0]    w_a_sa, w_b_sa_new;
    logic [c_PS_IW-1:0] w_vic_b;

    assign w_train    = v_in && w_tu_hit && (w_a != addr);
    assign w_alloc_a  = w_train && !w_a_hit;
    assign w_a_sa     = w_a_hit ? r_ps_sa[w_a_idx] : r_next_sa;
    assign w_b_sa_new = w_a_sa + 1'b1;
    assign w_full     = (w_b_sa_new & c_SL_MASK) == '0;
    assign w_b_seq    = w_b_hit && (r_ps_sa[w_b_idx] == w_b_sa_new);
    assign w_b_map    = w_train && !w_full &&
                        (!w_b_hit || (!w_b_seq && r_ps_conf[w_b_idx] == '0));
    assign w_alloc_b  = w_b_map && !w_b_hit;
    assign w_vic_b    = w_alloc_a ? r_rr + 1'b1 : r_rr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TU_ENTRIES; i++) begin
                r_tu_v[i]    <= 1'b0;
                r_tu_pc[i]   <= '0;
                r_tu_last[i] <= '0;
                r_tu_age[i]  <= c_TU_IW'(i);
            end
            for (int i = 0; i < PS_ENTRIES; i++) begin
                r_ps_v[i]    <= 1'b0;
                r_ps_addr[i] <= '0;
                r_ps_sa[i]   <= '0;
                r_ps_conf[i] <= '0;
            end
            for (int i = 0; i < c_SP_DEPTH; i++)
                r_sp_v[i] <= 1'b0;
            r_rr      <= '0;
            r_next_sa <= '0;
        end else if (v_in) begin
            for (int i = 0; i < TU_ENTRIES; i++) begin
                if (c_TU_IW'(i) == w_touch)
                    r_tu_age[i] <= '0;
                else if (r_tu_age[i] < r_tu_age[w_touch])
                    r_tu_age[i] <= r_tu_age[i] + 1'b1;
            end
            if (!w_tu_hit) begin
                r_tu_v[w_touch]    <= 1'b1;
                r_tu_pc[w_touch]   <= pc;
                r_tu_last[w_touch] <= addr;
            end else if (w_train) begin
                r_tu_last[w_touch] <= addr;
            end

            if (w_train && w_b_hit) begin
                if (w_b_seq) begin
                    if (r_ps_conf[w_b_idx] != {CONF_W{1'b1}})
                        r_ps_conf[w_b_idx] <= r_ps_conf[w_b_idx] + 1'b1;
                end else if (r_ps_conf[w_b_idx] != '0) begin
                    r_ps_conf[w_b_idx] <= r_ps_conf[w_b_idx] - 1'b1;
                end else if (!w_full) begin
                    r_ps_sa[w_b_idx] <= w_b_sa_new;
                end
            end
            if (w_alloc_a) begin
                r_ps_v[r_rr]    <= 1'b1;
                r_ps_addr[r_rr] <= w_a;
                r_ps_sa[r_rr]   <= r_next_sa;
                r_ps_conf[r_rr] <= '0;
                r_sp_v[r_next_sa] <= 1'b1;
                r_next_sa       <= r_next_sa + c_SL_STEP;
            end
            if (w_alloc_b) begin
                r_ps_v[w_vic_b]    <= 1'b1;
                r_ps_addr[w_vic_b] <= addr;
                r_ps_sa[w_vic_b]   <= w_b_sa_new;
                r_ps_conf[w_vic_b] <= '0;
            end
            if (w_b_map)
                r_sp_v[w_b_sa_new] <= 1'b1;
            r_rr <= r_rr + c_PS_IW'(w_alloc_a) + c_PS_IW'(w_alloc_b);
        end
    end

    // Physical addresses carry no reset: the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_alloc_a)
            r_sp_pa[r_next_sa] <= w_a;
        if (w_b_map)
            r_sp_pa[w_b_sa_new] <= addr;
    end

    logic [SA_W-1:0] w_fsa;
    logic            w_bound, w_last, w_drop;

    assign w_fsa   = r_base + SA_W'(r_k);
    assign w_bound = ({1'b0, r_base & c_SL_MASK} + (SA_W + 1)'(r_k)) >= (SA_W + 1)'(STREAM_LEN);
    assign w_last  = r_k == c_K_W'(DEGREE);

`ifdef ISB_PF_DEDUP_EN
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_last_pf;
    assign w_drop = (r_rd_pa == r_trig_addr) || (r_rd_pa == r_last_pf);
`else
    assign w_drop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_base    <= '0;
            r_k       <= '0;
            r_rd_v    <= 1'b0;
            r_rd_pa   <= '0;
            r_pf_v    <= 1'b0;
            r_pf_addr <= '0;
`ifdef ISB_PF_DEDUP_EN
            r_trig_addr <= '0;
            r_last_pf   <= '0;
`endif
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (v_in && w_b_hit) begin
                        r_base  <= r_ps_sa[w_b_idx];
                        r_k     <= c_K_W'(1);
                        r_state <= c_S_FETCH;
`ifdef ISB_PF_DEDUP_EN
                        r_trig_addr <= addr;
`endif
                    end
                end
                c_S_FETCH: begin
                    r_rd_v  <= !w_bound && r_sp_v[w_fsa];
                    r_rd_pa <= r_sp_pa[w_fsa];
                    r_state <= c_S_CHECK;
                end
                c_S_CHECK: begin
                    if (!r_rd_v) begin
                        r_state <= c_S_IDLE;
                    end else if (w_drop) begin
                        if (w_last) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= c_S_FETCH;
                        end
                    end else begin
                        r_pf_v    <= 1'b1;
                        r_pf_addr <= r_rd_pa;
                        r_state   <= c_S_SEND;
`ifdef ISB_PF_DEDUP_EN
                        r_last_pf <= r_rd_pa;
`endif
                    end
                end
                c_S_SEND: begin
                    if (prefetch_ready) begin
                        r_pf_v <= 1'b0;
                        if (w_last) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= c_S_FETCH;
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign prefetch_v    = r_pf_v;
    assign prefetch_addr = r_pf_addr;
    assign busy          = r_state != c_S_IDLE;

endmodule
`default_nettype wire

// File: tb/tb_isb_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_isb_param
// Brief    : Directed self-checking bench for isb_param (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_isb_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_in = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] addr = '0;
    logic        prefetch_ready = 1'b1;
    logic        prefetch_v;
    logic [15:0] prefetch_addr;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] pf_q[$];

    isb_param dut (
        .clk(clk), .rst(rst), .v_in(v_in), .pc(pc), .addr(addr),
        .prefetch_ready(prefetch_ready), .prefetch_v(prefetch_v),
        .prefetch_addr(prefetch_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Handshake log: one entry per accepted prefetch.
    always @(posedge clk)
        if (prefetch_v && prefetch_ready)
            pf_q.push_back(prefetch_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; v_in = 1'b0; prefetch_ready = 1'b1; pc = '0; addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pf_q.delete();
    endtask

    // Called at a negedge; presents one access for exactly one posedge.
    task automatic acc(input logic [15:0] p, input logic [15:0] a);
        pc = p; addr = a; v_in = 1'b1;
        @(negedge clk);
        v_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic train1();
        acc(16'h10, 16'h100);
        acc(16'h10, 16'h200);
        acc(16'h10, 16'h300);
    endtask

    initial begin
        // 1: basic chain, reset state and issue latency
        do_reset();
        chk("rst_pv", prefetch_v, 0);
        chk("rst_pa", prefetch_addr, 0);
        chk("rst_busy", busy, 0);
        train1();
        chk("s1_train_busy", busy, 0);
        acc(16'h10, 16'h100);
        chk("s1_t0_busy", busy, 1);
        chk("s1_t0_pv", prefetch_v, 0);
        @(negedge clk);
        chk("s1_t1_pv", prefetch_v, 0);
        @(negedge clk);
        chk("s1_t2_pv", prefetch_v, 1);
        chk("s1_t2_pa", prefetch_addr, 16'h200);
        @(negedge clk);
        chk("s1_t3_pv", prefetch_v, 0);
        repeat (2) @(negedge clk);
        chk("s1_t5_pv", prefetch_v, 1);
        chk("s1_t5_pa", prefetch_addr, 16'h300);
        wait_idle();
        chk("s1_cnt", pf_q.size(), 2);
        chk("s1_q0", pf_q[0], 16'h200);
        chk("s1_q1", pf_q[1], 16'h300);

        // 2: back-pressure holds output, mid-burst trigger ignored
        do_reset();
        train1();
        prefetch_ready = 1'b0;
        acc(16'h10, 16'h100);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                pc = 16'h77; addr = 16'h200; v_in = 1'b1;
            end
            @(negedge clk);
            v_in = 1'b0;
            chk("s2_hold_pv", prefetch_v, 1);
            chk("s2_hold_pa", prefetch_addr, 16'h200);
            chk("s2_hold_busy", busy, 1);
        end
        prefetch_ready = 1'b1;
        wait_idle();
        chk("s2_cnt", pf_q.size(), 2);
        chk("s2_q0", pf_q[0], 16'h200);
        chk("s2_q1", pf_q[1], 16'h300);

        // 3a: conf 0 -> 0x500 takes sa16, 0x200 remapped to sa17
        do_reset();
        train1();
        acc(16'h20, 16'h500);
        acc(16'h20, 16'h200);
        wait_idle();
        chk("s3a_trig_cnt", pf_q.size(), 1);
        chk("s3a_trig_q0", pf_q[0], 16'h300);
        pf_q.delete();
        acc(16'h21, 16'h500);
        wait_idle();
        chk("s3a_sa16_cnt", pf_q.size(), 1);
        chk("s3a_sa16_q0", pf_q[0], 16'h200);
        pf_q.delete();
        acc(16'h22, 16'h200);
        wait_idle();
        chk("s3a_sa17_cnt", pf_q.size(), 0);

        // 3b: conf 1 -> decremented, 0x200 keeps sa1
        do_reset();
        train1();
        acc(16'h11, 16'h100);
        acc(16'h11, 16'h200);
        wait_idle();
        acc(16'h20, 16'h500);
        acc(16'h20, 16'h200);
        wait_idle();
        pf_q.delete();
        acc(16'h21, 16'h200);
        wait_idle();
        chk("s3b_kept_cnt", pf_q.size(), 1);
        chk("s3b_kept_q0", pf_q[0], 16'h300);
        pf_q.delete();
        acc(16'h22, 16'h500);
        wait_idle();
        chk("s3b_sa17_cnt", pf_q.size(), 0);

        // 4: stream capacity and boundary
        do_reset();
        for (int i = 0; i < 17; i++)
            acc(16'h30, 16'(16'h1000 + i * 16));
        chk("s4_train_busy", busy, 0);
        acc(16'h31, 16'h10E0);
        wait_idle();
        chk("s4_cnt", pf_q.size(), 1);
        chk("s4_q0", pf_q[0], 16'h10F0);
        pf_q.delete();
        acc(16'h32, 16'h1100);
        chk("s4_unmapped_busy", busy, 0);
        acc(16'h33, 16'h10F0);
        wait_idle();
        chk("s4_edge_cnt", pf_q.size(), 0);

        // 5: TU LRU eviction
        do_reset();
        for (int i = 1; i <= 5; i++)
            acc(16'(i), 16'(16'h2000 + (i - 1) * 16));
        acc(16'h1, 16'h2100);
        chk("s5_busy", busy, 0);
        acc(16'h40, 16'h2000);
        chk("s5_no_trig", busy, 0);
        wait_idle();
        chk("s5_cnt", pf_q.size(), 0);

        // 5b: asynchronous reset during SEND
        do_reset();
        train1();
        prefetch_ready = 1'b0;
        acc(16'h10, 16'h100);
        repeat (2) @(negedge clk);
        chk("s5r_pre_pv", prefetch_v, 1);
        #2 rst = 1'b1;
        #1;
        chk("s5r_pv", prefetch_v, 0);
        chk("s5r_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        prefetch_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("s5r_after_pv", prefetch_v, 0);
        chk("s5r_cnt", pf_q.size(), 0);

        // 6: candidate equal to trigger address
        do_reset();
        acc(16'h10, 16'h100);
        acc(16'h10, 16'h200);
        acc(16'h10, 16'h100);
        wait_idle();
        chk("s6_q0", pf_q[0], 16'h200);
`ifdef ISB_PF_DEDUP_EN
        chk("s6_cnt", pf_q.size(), 1);
`else
        chk("s6_cnt", pf_q.size(), 2);
        chk("s6_q1", pf_q[1], 16'h100);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
